// File: rtl/multicycle_ctrl.sv
// Multicycle sequencing FSM for the RV32I core: fetch/decode/execute/mem/wb over one memory port.
// Optional performance counters are enabled with the MULTICYCLE_CTRL_PERF_CNT_EN macro.
module multicycle_ctrl #(
    parameter int unsigned TIMEOUT_W = 8,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 op_valid,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic                 RegWrite,
    input  logic                 Branch,
    input  logic                 mem_ready,
    output logic                 MemReq,
    output logic                 MemWe,
    output logic                 AdrSrc,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 BranchEval,
    output logic                 RegWriteEn,
    output logic                 instr_done,
    output logic                 busy,
    output logic                 fault,
    output logic [2:0]           state,
    output logic [CNT_WIDTH-1:0] retired_count,
    output logic [CNT_WIDTH-1:0] cycle_count
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StFetch   = 3'd1,
        StDecode  = 3'd2,
        StExecute = 3'd3,
        StMem     = 3'd4,
        StWb      = 3'd5,
        StFault   = 3'd7
    } state_e;

    state_e               state_q, state_d, retire_next;
    logic                 l_mem_read_q, l_mem_write_q, l_reg_write_q, l_branch_q;
    logic [TIMEOUT_W-1:0] wdog_q;
    logic                 wdog_expired, mem_wait;
    logic                 retire, ir_load;
    logic                 mem_req_q, mem_we_q, adr_src_q, branch_eval_q;
    logic                 reg_write_en_q, busy_q, fault_q;

    assign wdog_expired = (wdog_q == {TIMEOUT_W{1'b1}});
    assign mem_wait     = ((state_q == StFetch) || (state_q == StMem)) && !mem_ready;
    assign retire_next  = run ? StFetch : StIdle;

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        ir_load = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run) state_d = StFetch;
            end
            StFetch: begin
                if (wdog_expired) begin
                    state_d = StFault;
                end else if (mem_ready) begin
                    ir_load = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (!op_valid || (MemRead && MemWrite)) state_d = StFault;
                else                                    state_d = StExecute;
            end
            StExecute: begin
                if (l_mem_read_q || l_mem_write_q) begin
                    state_d = StMem;
                end else if (l_reg_write_q) begin
                    state_d = StWb;
                end else begin
                    retire  = 1'b1;
                    state_d = retire_next;
                end
            end
            StMem: begin
                if (wdog_expired) begin
                    state_d = StFault;
                end else if (mem_ready) begin
                    if (l_mem_write_q) begin
                        retire  = 1'b1;
                        state_d = retire_next;
                    end else begin
                        state_d = StWb;
                    end
                end
            end
            StWb: begin
                retire  = 1'b1;
                state_d = retire_next;
            end
            StFault: state_d = StFault;
            default: state_d = StFault;
        endcase
    end

    // Moore outputs are registered from the next state so they are glitch-free flop outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            l_mem_read_q   <= 1'b0;
            l_mem_write_q  <= 1'b0;
            l_reg_write_q  <= 1'b0;
            l_branch_q     <= 1'b0;
            wdog_q         <= '0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            adr_src_q      <= 1'b0;
            branch_eval_q  <= 1'b0;
            reg_write_en_q <= 1'b0;
            busy_q         <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) begin
                l_mem_read_q  <= MemRead;
                l_mem_write_q <= MemWrite;
                l_reg_write_q <= RegWrite;
                l_branch_q    <= Branch;
            end
            wdog_q         <= mem_wait ? wdog_q + 1'b1 : '0;
            mem_req_q      <= (state_d == StFetch) || (state_d == StMem);
            adr_src_q      <= (state_d == StMem);
            mem_we_q       <= (state_d == StMem) && l_mem_write_q;
            // EXECUTE is only entered from DECODE, so the live Branch is what gets latched.
            branch_eval_q  <= (state_d == StExecute) && Branch;
            reg_write_en_q <= (state_d == StWb);
            busy_q         <= (state_d != StIdle) && (state_d != StFault);
            fault_q        <= (state_d == StFault);
        end
    end

    // Mealy strobes are suppressed during reset so an aborted instruction never retires.
    assign IRWrite    = ir_load && !rst;
    assign PCWrite    = retire && !rst;
    assign instr_done = retire && !rst;

    assign MemReq     = mem_req_q;
    assign MemWe      = mem_we_q;
    assign AdrSrc     = adr_src_q;
    assign BranchEval = branch_eval_q;
    assign RegWriteEn = reg_write_en_q;
    assign busy       = busy_q;
    assign fault      = fault_q;
    assign state      = state_q;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] retired_q, cycles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            retired_q <= '0;
            cycles_q  <= '0;
        end else begin
            if (instr_done) retired_q <= retired_q + 1'b1;
            if (busy_q)     cycles_q  <= cycles_q + 1'b1;
        end
    end

    assign retired_count = retired_q;
    assign cycle_count   = cycles_q;
`else
    assign retired_count = '0;
    assign cycle_count   = '0;
`endif

endmodule
